// File: rtl/aes_pkg.sv
// Shared AES definitions: round constants, S-box, GF(2^8) doubling and the
// key-schedule FSM state encoding.
package aes_pkg;

  localparam int AES_NK      = 4;
  localparam int AES_NROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } aes_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) modulo the AES polynomial; advances rcon.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_subword.sv
// Combinational SubWord: four parallel S-box lookups with zero latency, so the
// key schedule can produce one round key per cycle.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] sub
);

  assign sub = {SBOX[word[31:24]], SBOX[word[23:16]], SBOX[word[15:8]], SBOX[word[7:0]]};

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule streaming rk0..rkN over a valid/ready port.
// Optional AES_KEY_EXPAND_STORE_EN builds an (N+1)x128 key store read via rd_addr.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NROUNDS = AES_NROUNDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_index,
  output logic         done,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_key
);

  localparam logic [3:0] LAST_INDEX = 4'(NROUNDS);

  aes_state_e   state;
  logic [7:0]   rcon;
  logic [31:0]  rot_w3;
  logic [31:0]  sub_w3;
  logic [31:0]  t_word;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_rk;
  logic         xfer;

  assign xfer   = (state == STREAM) && rk_ready;
  assign rot_w3 = {rk[23:0], rk[31:24]};

  aes_subword u_subword (
    .word (rot_w3),
    .sub  (sub_w3)
  );

  assign t_word  = sub_w3 ^ {rcon, 24'h0};
  assign n0      = rk[127:96] ^ t_word;
  assign n1      = rk[95:64]  ^ n0;
  assign n2      = rk[63:32]  ^ n1;
  assign n3      = rk[31:0]   ^ n2;
  assign next_rk = {n0, n1, n2, n3};

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would chain rk/rcon updates within one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rk       <= '0;
      rk_index <= '0;
      rcon     <= 8'h01;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= STREAM;
            rk       <= key_in;
            rk_index <= '0;
            rcon     <= 8'h01;
            busy     <= 1'b1;
            rk_valid <= 1'b1;
          end
        end
        STREAM: begin
          if (rk_ready) begin
            if (rk_index == LAST_INDEX) begin
              state    <= DONE;
              rk_valid <= 1'b0;
              done     <= 1'b1;
            end else begin
              rk       <= next_rk;
              rk_index <= rk_index + 4'd1;
              rcon     <= xtime(rcon);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AES_KEY_EXPAND_STORE_EN
  logic [127:0] key_store [NROUNDS+1];

  // NOTE: the store has no reset; its contents survive rst so previously
  // expanded keys remain readable, and it maps onto plain registers/RAM.
  always_ff @(posedge clk) begin
    if (!rst && xfer) begin
      key_store[rk_index] <= rk;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_key <= '0;
    end else if (rd_addr <= LAST_INDEX) begin
      rd_key <= key_store[rd_addr];
    end else begin
      rd_key <= '0;
    end
  end
`else
  logic unused_rd;

  assign rd_key    = '0;
  assign unused_rd = ^{rd_addr, xfer};
`endif

endmodule
